// File: rtl/instr_buffer_pkg.sv
// Shared types and default sizes for the IF->ID instruction buffer.
//   instr_buffer_info_t : one fetched instruction slot (valid, pc, instr, excp, excp_num)
//   *Default constants  : default depth and per-cycle fetch/decode widths
package instr_buffer_pkg;

  localparam int unsigned IbDepthDefault     = 8;
  localparam int unsigned FetchWidthDefault  = 2;
  localparam int unsigned DecodeWidthDefault = 2;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        excp;
    logic [5:0]  excp_num;
  } instr_buffer_info_t;

endpackage

// File: rtl/instr_buffer.sv
// Circular FIFO between fetch (IF) and decode (ID).
// Absorbs fetch bursts and presents up to DecodeWidth in-order entries per cycle.
// Ports:
//   clk                 : clock, rising edge
//   rst_n               : asynchronous active-low reset
//   flush_i             : synchronous discard of all contents (wins over push/pop)
//   fetch_instr_i       : FetchWidth lanes from fetch, .valid marks a real instruction
//   frontend_stallreq_o : fetch must hold; lanes offered this cycle are dropped
//   backend_instr_o     : DecodeWidth head entries, all-zero beyond the occupied count
//   backend_accept_i    : per-lane consume strobe from decode (must be a prefix)
module instr_buffer
  import instr_buffer_pkg::*;
#(
  parameter int unsigned IbDepth     = IbDepthDefault,
  parameter int unsigned FetchWidth  = FetchWidthDefault,
  parameter int unsigned DecodeWidth = DecodeWidthDefault
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  instr_buffer_info_t     fetch_instr_i [FetchWidth],
  output logic                   frontend_stallreq_o,
  output instr_buffer_info_t     backend_instr_o [DecodeWidth],
  input  logic [DecodeWidth-1:0] backend_accept_i
);

  localparam int unsigned PtrW = $clog2(IbDepth);
  localparam int unsigned CntW = PtrW + 1;
  // Stall once fewer than FetchWidth free slots remain.
  localparam logic [CntW-1:0] StallLevel = CntW'(IbDepth - FetchWidth);

  instr_buffer_info_t     mem_q [IbDepth];
  logic [PtrW-1:0]        head_q, tail_q;
  logic [CntW-1:0]        count_q, count_d;
  logic [PtrW-1:0]        slot [FetchWidth];
  logic [CntW-1:0]        push_num, pop_num;
  logic                   push_en, pop_run;
  logic [DecodeWidth-1:0] accept_eff;

  always_comb begin
    // Stall depends only on the registered count, so a full buffer stalls even while popping.
    frontend_stallreq_o = count_q > StallLevel;
    push_en             = !frontend_stallreq_o && !flush_i;

    // Pack valid lanes: each valid lane lands at tail + (valid lanes below it).
    push_num = '0;
    for (int i = 0; i < FetchWidth; i++) begin
      slot[i] = push_num[PtrW-1:0];
      if (fetch_instr_i[i].valid) push_num = push_num + CntW'(1);
    end
    if (!push_en) push_num = '0;

    for (int i = 0; i < DecodeWidth; i++) begin
      if (CntW'(i) < count_q) backend_instr_o[i] = mem_q[head_q + PtrW'(i)];
      else                    backend_instr_o[i] = '0;
      accept_eff[i] = backend_accept_i[i] && backend_instr_o[i].valid;
    end

    // Pop only the leading run of accepted lanes; a gap ends the run.
    pop_num = '0;
    pop_run = 1'b1;
    for (int i = 0; i < DecodeWidth; i++) begin
      if (pop_run && accept_eff[i]) pop_num = pop_num + CntW'(1);
      else                          pop_run = 1'b0;
    end

    count_d = count_q + push_num - pop_num;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int k = 0; k < IbDepth; k++) mem_q[k] <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int k = 0; k < IbDepth; k++) mem_q[k].valid <= 1'b0;
    end else begin
      for (int i = 0; i < FetchWidth; i++) begin
        if (push_en && fetch_instr_i[i].valid) mem_q[tail_q + slot[i]] <= fetch_instr_i[i];
      end
      tail_q  <= tail_q + push_num[PtrW-1:0];
      head_q  <= head_q + pop_num[PtrW-1:0];
      count_q <= count_d;
    end
  end

  count_le_depth: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CntW'(IbDepth));

  no_push_when_stall: assert property (@(posedge clk) disable iff (!rst_n)
    frontend_stallreq_o |-> (push_num == '0));

  // Checked on lanes that carry a valid entry; accepts on empty lanes are don't-care.
  accept_is_prefix: assert property (@(posedge clk) disable iff (!rst_n)
    (accept_eff & (accept_eff + DecodeWidth'(1))) == '0);

endmodule
